// File: rtl/note_player_if.sv
// Read side of the song FIFO (standard read mode with a valid strobe).
// The player is the master: it issues reads, the FIFO answers with data.
interface note_player_if;
  logic [14:0] fifo_dout;
  logic        fifo_valid;
  logic        fifo_empty;
  logic        fifo_rd_en;

  modport master (
    output fifo_rd_en,
    input  fifo_dout,
    input  fifo_valid,
    input  fifo_empty
  );

  modport slave (
    input  fifo_rd_en,
    output fifo_dout,
    output fifo_valid,
    output fifo_empty
  );
endinterface

// File: rtl/note_player.sv
// Pops frequency words from the song FIFO and plays each as a square wave for a
// fixed duration, followed by a silent gap. Tone pitch comes from a modulo accumulator.
module note_player #(
  parameter int unsigned CLK_HZ      = 100_000_000,
  parameter int unsigned NOTE_CYCLES = 25_000_000,
  parameter int unsigned GAP_CYCLES  = 1_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  note_player_if.master fifo,
  output logic        tone_out,
  output logic        playing,
  output logic [14:0] cur_freq,
  output logic        note_done,
  output logic        rd_timeout
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_PLAY,
    S_GAP
  } state_t;

  localparam logic [31:0] MODULUS   = 32'(CLK_HZ);
  localparam logic [31:0] NOTE_LAST = 32'(NOTE_CYCLES - 1);
  localparam logic [31:0] GAP_LAST  = (GAP_CYCLES == 0) ? 32'd0 : 32'(GAP_CYCLES - 1);
  localparam logic [1:0]  WAIT_LAST = 2'd3;

  state_t      r_state;
  logic [31:0] r_acc;
  logic [31:0] r_note_cnt;
  logic [31:0] r_gap_cnt;
  logic [1:0]  r_wait_cnt;
  logic        r_rd_en;
  logic        r_tone;
  logic        r_playing;
  logic [14:0] r_cur_freq;
  logic        r_note_done;
  logic        r_rd_timeout;

  logic [31:0] w_sum;
  logic        w_wrap;

  // Phase advances by twice the frequency so one wrap equals one half-period.
  assign w_sum  = r_acc + {16'd0, r_cur_freq, 1'b0};
  assign w_wrap = (w_sum >= MODULUS);

  // NOTE: all state and outputs update with non-blocking assignments in one
  // clocked block, so every output is a flop and reset is synchronous.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_acc        <= '0;
      r_note_cnt   <= '0;
      r_gap_cnt    <= '0;
      r_wait_cnt   <= '0;
      r_rd_en      <= 1'b0;
      r_tone       <= 1'b0;
      r_playing    <= 1'b0;
      r_cur_freq   <= '0;
      r_note_done  <= 1'b0;
      r_rd_timeout <= 1'b0;
    end else begin
      r_rd_en      <= 1'b0;
      r_note_done  <= 1'b0;
      r_rd_timeout <= 1'b0;

      unique case (r_state)
        S_IDLE: begin
          if (enable && !fifo.fifo_empty) begin
            r_state <= S_REQ;
            r_rd_en <= 1'b1;
          end
        end

        S_REQ: begin
          r_state    <= S_WAIT;
          r_wait_cnt <= '0;
        end

        S_WAIT: begin
          if (fifo.fifo_valid) begin
            r_cur_freq <= fifo.fifo_dout;
            r_acc      <= '0;
            r_note_cnt <= '0;
            r_playing  <= 1'b1;
            r_state    <= S_PLAY;
          end else if (r_wait_cnt == WAIT_LAST) begin
            r_rd_timeout <= 1'b1;
            r_state      <= S_IDLE;
          end else begin
            r_wait_cnt <= r_wait_cnt + 2'd1;
          end
        end

        S_PLAY: begin
          if (r_note_cnt == NOTE_LAST) begin
            r_playing   <= 1'b0;
            r_tone      <= 1'b0;
            r_acc       <= '0;
            r_note_done <= 1'b1;
            r_gap_cnt   <= '0;
            r_state     <= (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
          end else begin
            r_note_cnt <= r_note_cnt + 32'd1;
            if (w_wrap) begin
              r_acc  <= w_sum - MODULUS;
              r_tone <= ~r_tone;
            end else begin
              r_acc <= w_sum;
            end
          end
        end

        S_GAP: begin
          if (r_gap_cnt == GAP_LAST) begin
            r_state <= S_IDLE;
          end else begin
            r_gap_cnt <= r_gap_cnt + 32'd1;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign fifo.fifo_rd_en = r_rd_en;
  assign tone_out        = r_tone;
  assign playing         = r_playing;
  assign cur_freq        = r_cur_freq;
  assign note_done       = r_note_done;
  assign rd_timeout      = r_rd_timeout;

endmodule

// File: tb/tb_note_player.sv
// Bench for note_player: a queue-backed FIFO model with read latency 1, a table of
// known notes, hand-written corner sequences, and random notes checked against a closed-form tone model.
module tb_note_player;

  localparam int CLK  = 1000;
  localparam int NOTE = 100;
  localparam int GAP  = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        tone_out;
  logic        playing;
  logic [14:0] cur_freq;
  logic        note_done;
  logic        rd_timeout;

  note_player_if u_if ();

  note_player #(
    .CLK_HZ     (CLK),
    .NOTE_CYCLES(NOTE),
    .GAP_CYCLES (GAP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .fifo      (u_if.master),
    .tone_out  (tone_out),
    .playing   (playing),
    .cur_freq  (cur_freq),
    .note_done (note_done),
    .rd_timeout(rd_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    int freq;
    int first_rise;
    int trans;
  } vec_t;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  logic [14:0] q[$];
  bit          drop_resp = 1'b0;
  int          rd_count = 0;
  int          done_count = 0;
  int          to_count = 0;
  int          long_pulse = 0;
  int          last_rd_cyc = 0;
  int          last_to_cyc = 0;
  bit          pending = 1'b0;
  logic [14:0] pend_data = '0;
  bit          prev_rd = 1'b0;
  bit          prev_done = 1'b0;
  bit          prev_to = 1'b0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // FIFO model and pulse monitor; runs on the falling edge, away from DUT updates.
  initial begin
    u_if.fifo_valid = 1'b0;
    u_if.fifo_dout  = '0;
    u_if.fifo_empty = 1'b1;
    forever begin
      @(negedge clk);
      if (pending) begin
        u_if.fifo_valid = 1'b1;
        u_if.fifo_dout  = pend_data;
        pending         = 1'b0;
      end else begin
        u_if.fifo_valid = 1'b0;
      end
      if (u_if.fifo_rd_en) begin
        rd_count++;
        last_rd_cyc = cyc;
        if (!drop_resp && q.size() > 0) begin
          pend_data = q.pop_front();
          pending   = 1'b1;
        end
      end
      if (note_done) done_count++;
      if (rd_timeout) begin
        to_count++;
        last_to_cyc = cyc;
      end
      if ((u_if.fifo_rd_en && prev_rd) || (note_done && prev_done) || (rd_timeout && prev_to))
        long_pulse++;
      prev_rd   = u_if.fifo_rd_en;
      prev_done = note_done;
      prev_to   = rd_timeout;
      u_if.fifo_empty = (q.size() == 0);
    end
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input int w);
    q.push_back(15'(w));
    u_if.fifo_empty = 1'b0;
  endtask

  // Closed-form tone after j PLAY cycles: number of half-periods elapsed, taken mod 2.
  function automatic logic exp_tone(input int j, input int f);
    return logic'(((j * 2 * f) / CLK) % 2);
  endfunction

  function automatic int exp_trans(input int f);
    int toggles;
    toggles = ((NOTE - 1) * 2 * f) / CLK;
    return toggles + (toggles % 2);
  endfunction

  task automatic wait_playing(input int budget, output bit ok);
    int waited = 0;
    while (!playing && waited < budget) begin
      step();
      waited++;
    end
    ok = playing;
  endtask

  // Follows one note from its first PLAY cycle through the gap and fetch dead time.
  task automatic observe_note(input int f, output int first_rise, output int trans,
                              output int wave_err, output int start_cyc, output int done_cyc);
    bit   ok;
    logic prev;
    first_rise = -1;
    trans      = 0;
    wave_err   = 0;
    start_cyc  = -1;
    done_cyc   = -1;
    wait_playing(60, ok);
    if (!ok) begin
      check("play_start_timeout", 0, 1);
      return;
    end
    start_cyc = cyc;
    prev      = 1'b0;
    for (int j = 0; j < NOTE; j++) begin
      if (j > 0) step();
      if (!playing || cur_freq != 15'(f) || tone_out !== exp_tone(j, f)) wave_err++;
      if (tone_out != prev) trans++;
      if (tone_out && first_rise < 0) first_rise = j;
      prev = tone_out;
    end
    step();
    done_cyc = cyc;
    if (playing || !note_done || tone_out) wave_err++;
    if (tone_out != prev) trans++;
    for (int g = 1; g < GAP + 3; g++) begin
      step();
      if (tone_out || playing || note_done) wave_err++;
    end
  endtask

  vec_t vecs[7];
  int   fr, tr, we, sc, dc, prev_dc;
  int   rd0, done0, to0, nz, waited;
  bit   ok;
  int   rnd_f[8];

  initial begin
    vecs[0] = '{freq: 100, first_rise: 5, trans: 20};
    vecs[1] = '{freq: 250, first_rise: 2, trans: 50};
    vecs[2] = '{freq: 0,   first_rise: -1, trans: 0};
    vecs[3] = '{freq: 440, first_rise: 2, trans: 88};
    vecs[4] = '{freq: 500, first_rise: 1, trans: 100};
    vecs[5] = '{freq: 125, first_rise: 4, trans: 24};
    vecs[6] = '{freq: 333, first_rise: 2, trans: 66};

    // Reset with an empty FIFO and enable high: nothing may happen.
    rst    = 1'b1;
    enable = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    step();
    check("rst_tone", int'(tone_out === 1'b0), 1);
    check("rst_playing", int'(playing === 1'b0), 1);
    check("rst_cur_freq", int'(cur_freq === 15'd0), 1);
    check("rst_note_done", int'(note_done === 1'b0), 1);
    check("rst_rd_timeout", int'(rd_timeout === 1'b0), 1);
    check("rst_rd_en", int'(u_if.fifo_rd_en === 1'b0), 1);
    nz = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (tone_out || playing || cur_freq != 0 || note_done || rd_timeout || u_if.fifo_rd_en) nz++;
    end
    check("empty_idle_active_cycles", nz, 0);
    check("empty_idle_reads", rd_count, 0);

    // Single note: read latency, table expectations.
    push(vecs[0].freq);
    observe_note(vecs[0].freq, fr, tr, we, sc, dc);
    check("n0_first_rise", fr, vecs[0].first_rise);
    check("n0_transitions", tr, vecs[0].trans);
    check("n0_wave_errors", we, 0);
    check("n0_read_to_play", sc - last_rd_cyc, 2);
    check("n0_reads", rd_count, 1);
    check("n0_done", done_count, 1);

    // Remaining table notes back-to-back.
    for (int i = 1; i < 7; i++) push(vecs[i].freq);
    prev_dc = -1;
    for (int i = 1; i < 7; i++) begin
      observe_note(vecs[i].freq, fr, tr, we, sc, dc);
      check($sformatf("vec%0d_first_rise", i), fr, vecs[i].first_rise);
      check($sformatf("vec%0d_transitions", i), tr, vecs[i].trans);
      check($sformatf("vec%0d_wave_errors", i), we, 0);
      if (prev_dc >= 0) check($sformatf("vec%0d_dead_time", i), sc - prev_dc, GAP + 3);
      prev_dc = dc;
    end
    check("table_reads", rd_count, 7);
    check("table_done", done_count, 7);

    // Drop enable mid-PLAY with two notes queued.
    rd0   = rd_count;
    done0 = done_count;
    push(200);
    push(300);
    wait_playing(60, ok);
    check("en_drop_play_started", int'(ok), 1);
    repeat (30) step();
    enable = 1'b0;
    repeat (120) step();
    check("en_drop_reads", rd_count - rd0, 1);
    check("en_drop_done", done_count - done0, 1);
    check("en_drop_queue_left", q.size(), 1);
    check("en_drop_idle", int'(playing || tone_out), 0);
    enable = 1'b1;
    observe_note(300, fr, tr, we, sc, dc);
    check("en_resume_wave_errors", we, 0);
    check("en_resume_reads", rd_count - rd0, 2);

    // Reset in the middle of a note.
    push(150);
    push(350);
    wait_playing(60, ok);
    check("rst_mid_play_started", int'(ok), 1);
    repeat (39) step();
    rst = 1'b1;
    step();
    nz = 0;
    if (tone_out || playing || cur_freq != 0 || note_done || rd_timeout || u_if.fifo_rd_en) nz++;
    check("rst_mid_outputs_nonzero", nz, 0);
    check("rst_mid_queue_left", q.size(), 1);
    rst = 1'b0;
    observe_note(350, fr, tr, we, sc, dc);
    check("rst_mid_restart_wave_errors", we, 0);
    check("rst_mid_restart_transitions", tr, exp_trans(350));

    // Read with no valid response.
    drop_resp = 1'b1;
    rd0       = rd_count;
    to0       = to_count;
    push(77);
    waited = 0;
    while (rd_count == rd0 && waited < 20) begin
      step();
      waited++;
    end
    check("timeout_read_issued", int'(rd_count > rd0), 1);
    enable = 1'b0;
    waited = 0;
    while (to_count == to0 && waited < 20) begin
      step();
      waited++;
    end
    check("timeout_pulses", to_count - to0, 1);
    check("timeout_delay", last_to_cyc - last_rd_cyc, 5);
    repeat (20) step();
    check("timeout_no_retry", rd_count - rd0, 1);
    check("timeout_single_pulse", to_count - to0, 1);
    check("timeout_not_playing", int'(playing), 0);
    drop_resp = 1'b0;
    enable    = 1'b1;
    observe_note(77, fr, tr, we, sc, dc);
    check("timeout_recover_wave_errors", we, 0);

    // Random notes against the closed-form model.
    for (int r = 0; r < 8; r++) begin
      rnd_f[r] = int'($urandom_range(0, CLK / 2));
      push(rnd_f[r]);
    end
    prev_dc = -1;
    for (int r = 0; r < 8; r++) begin
      observe_note(rnd_f[r], fr, tr, we, sc, dc);
      check($sformatf("rnd%0d_f%0d_wave_errors", r, rnd_f[r]), we, 0);
      check($sformatf("rnd%0d_f%0d_transitions", r, rnd_f[r]), tr, exp_trans(rnd_f[r]));
      if (prev_dc >= 0) check($sformatf("rnd%0d_dead_time", r), sc - prev_dc, GAP + 3);
      prev_dc = dc;
    end

    check("pulse_widths_over_one", long_pulse, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
